sa_wb_agen: RTL and testbench

//  Parametrised write-back address generator and arbiter for the systolic-array bank.

---
 rtl/sa_wb_agen.sv | 206 ++++++++++++++++++++
 tb/tb_sa_wb_agen.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_wb_agen.sv
// Write-back address generator: per-SA FIFOs tag pooled values with SRAM addresses,
// then a round-robin arbiter funnels them through one registered valid/ready write port.
module sa_wb_agen #(
  parameter int SA_NUM     = 4,
  parameter int DIM        = 4,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cfg_load,
  input  logic                          cfg_vmode,
  input  logic [$clog2(SA_NUM):0]       cfg_sa_num,
  input  logic [ADDR_W-1:0]             cfg_base_addr,
  input  logic [SA_NUM*DIM-1:0]         pool_rd_en,
  input  logic [SA_NUM*DIM*DATA_W-1:0]  pool_data,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [SA_NUM-1:0]             fifo_full,
  output logic                          busy,
  output logic                          err_overflow
);

  localparam int SN_W  = $clog2(SA_NUM) + 1;
  localparam int SA_W  = (SA_NUM > 1) ? $clog2(SA_NUM) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DIM * SA_NUM + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  // Valid/ready: wr_valid, wr_addr and wr_data come straight from the output-stage flops;
  // once wr_valid is high they hold until a cycle with wr_valid && wr_ready, and the
  // stage only reloads on the cycle after that handshake.

  logic                  vmode_q;
  logic [SN_W-1:0]       sa_num_q;
  logic [CNT_W-1:0]      chunk_q;
  logic [ADDR_W-1:0]     stride_q;
  logic [ADDR_W-1:0]     base_q [SA_NUM];
  logic [CNT_W-1:0]      cnt_q  [SA_NUM];
  logic [PW:0]           wptr_q [SA_NUM];
  logic [PW:0]           rptr_q [SA_NUM];
  logic [ENT_W-1:0]      mem_q  [SA_NUM][FIFO_DEPTH];

  logic                  out_valid_q;
  logic [ADDR_W-1:0]     out_addr_q;
  logic [DATA_W-1:0]     out_data_q;
  logic [SA_W-1:0]       out_sa_q;
  logic [SA_W-1:0]       rr_ptr_q;
  logic                  err_q;

  logic [SN_W-1:0]       cfg_sa_clamped;
  logic [CNT_W-1:0]      cfg_chunk;
  logic [ADDR_W-1:0]     cfg_stride;
  logic [ADDR_W-1:0]     cfg_base [SA_NUM];

  logic [SA_NUM-1:0]     active;
  logic [SA_NUM-1:0]     push_req;
  logic [SA_NUM-1:0]     push_ok;
  logic [SA_NUM-1:0]     overflow;
  logic [SA_NUM-1:0]     full;
  logic [SA_NUM-1:0]     empty;
  logic [SA_NUM-1:0]     pop;
  logic [DATA_W-1:0]     push_data [SA_NUM];
  logic [ADDR_W-1:0]     push_addr [SA_NUM];
  logic [PW:0]           fill      [SA_NUM];

  logic                  gnt_found;
  logic [SA_W-1:0]       gnt_idx;
  logic [ENT_W-1:0]      gnt_entry;
  logic                  load;
  logic [SA_W-1:0]       rr_next;
  int                    rr_idx;

  // Configuration decode, evaluated on the raw cfg_* inputs for use at cfg_load.
  always_comb begin
    cfg_sa_clamped = (int'(cfg_sa_num) > SA_NUM) ? SN_W'(SA_NUM) : cfg_sa_num;
    cfg_chunk  = cfg_vmode ? CNT_W'(DIM) : CNT_W'(DIM * int'(cfg_sa_clamped));
    cfg_stride = cfg_vmode ? ADDR_W'(DIM)
                           : ADDR_W'(DIM * int'(cfg_sa_clamped) * int'(cfg_sa_clamped));
    for (int i = 0; i < SA_NUM; i++) begin
      cfg_base[i] = cfg_vmode ? cfg_base_addr
                              : cfg_base_addr + ADDR_W'(i * DIM * int'(cfg_sa_clamped));
    end
  end

  // Per-SA active set, lane priority select and FIFO occupancy.
  always_comb begin
    for (int i = 0; i < SA_NUM; i++) begin
      if (vmode_q) active[i] = (sa_num_q != '0) && (int'(sa_num_q) == i + 1);
      else         active[i] = (i < int'(sa_num_q));

      push_data[i] = '0;
      for (int l = DIM - 1; l >= 0; l--) begin
        if (pool_rd_en[i*DIM + l]) push_data[i] = pool_data[(i*DIM + l)*DATA_W +: DATA_W];
      end
      push_addr[i] = base_q[i] + ADDR_W'(cnt_q[i]);
      push_req[i]  = !cfg_load && active[i] && (|pool_rd_en[i*DIM +: DIM]);

      fill[i]  = wptr_q[i] - rptr_q[i];
      full[i]  = (fill[i] == (PW+1)'(FIFO_DEPTH));
      empty[i] = (wptr_q[i] == rptr_q[i]);
    end
  end

  // Round-robin search starting at rr_ptr_q (one past the last accepted SA).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_idx    = 0;
    for (int k = 0; k < SA_NUM; k++) begin
      rr_idx = (int'(rr_ptr_q) + k) % SA_NUM;
      if (!gnt_found && !empty[rr_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = SA_W'(rr_idx);
      end
    end
  end

  assign gnt_entry = mem_q[gnt_idx][rptr_q[gnt_idx][PW-1:0]];
  assign load      = !out_valid_q && gnt_found && !cfg_load;
  assign rr_next   = (int'(out_sa_q) == SA_NUM - 1) ? '0 : out_sa_q + SA_W'(1);

  // A push into a full FIFO is legal only when that FIFO is popped in the same cycle.
  always_comb begin
    for (int i = 0; i < SA_NUM; i++) begin
      pop[i]      = load && (gnt_idx == SA_W'(i));
      push_ok[i]  = push_req[i] && (!full[i] || pop[i]);
      overflow[i] = push_req[i] && full[i] && !pop[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SA_NUM; i++) begin
      if (push_ok[i]) mem_q[i][wptr_q[i][PW-1:0]] <= {push_addr[i], push_data[i]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vmode_q     <= 1'b0;
      sa_num_q    <= '0;
      chunk_q     <= '0;
      stride_q    <= '0;
      for (int i = 0; i < SA_NUM; i++) begin
        base_q[i] <= '0;
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_sa_q    <= '0;
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else if (cfg_load) begin
      vmode_q     <= cfg_vmode;
      sa_num_q    <= cfg_sa_clamped;
      chunk_q     <= cfg_chunk;
      stride_q    <= cfg_stride;
      for (int i = 0; i < SA_NUM; i++) begin
        base_q[i] <= cfg_base[i];
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < SA_NUM; i++) begin
        if (push_ok[i]) begin
          wptr_q[i] <= wptr_q[i] + (PW+1)'(1);
          if (cnt_q[i] + CNT_W'(1) == chunk_q) begin
            cnt_q[i]  <= '0;
            base_q[i] <= base_q[i] + stride_q;
          end else begin
            cnt_q[i]  <= cnt_q[i] + CNT_W'(1);
          end
        end
        if (pop[i]) rptr_q[i] <= rptr_q[i] + (PW+1)'(1);
      end
      if (|overflow) err_q <= 1'b1;

      if (out_valid_q && wr_ready) begin
        out_valid_q <= 1'b0;
        rr_ptr_q    <= rr_next;
      end else if (load) begin
        out_valid_q <= 1'b1;
        out_addr_q  <= gnt_entry[ENT_W-1:DATA_W];
        out_data_q  <= gnt_entry[DATA_W-1:0];
        out_sa_q    <= gnt_idx;
      end
    end
  end

  assign wr_valid     = out_valid_q;
  assign wr_addr      = out_addr_q;
  assign wr_data      = out_data_q;
  assign fifo_full    = full;
  assign busy         = out_valid_q || !(&empty);
  assign err_overflow = err_q;

endmodule

// File: tb/tb_sa_wb_agen.sv
// Self-checking bench for sa_wb_agen: per-SA expected queues filled by the push driver,
// drained by a write monitor that identifies the source SA from the data tag.
module tb_sa_wb_agen;

  localparam int SA_NUM     = 4;
  localparam int DIM        = 4;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int SN_W       = $clog2(SA_NUM) + 1;
  localparam int W          = ADDR_W + DATA_W;

  logic                         clk;
  logic                         resetn;
  logic                         cfg_load;
  logic                         cfg_vmode;
  logic [SN_W-1:0]              cfg_sa_num;
  logic [ADDR_W-1:0]            cfg_base_addr;
  logic [SA_NUM*DIM-1:0]        pool_rd_en;
  logic [SA_NUM*DIM*DATA_W-1:0] pool_data;
  logic                         wr_valid;
  logic                         wr_ready;
  logic [ADDR_W-1:0]            wr_addr;
  logic [DATA_W-1:0]            wr_data;
  logic [SA_NUM-1:0]            fifo_full;
  logic                         busy;
  logic                         err_overflow;

  sa_wb_agen #(
    .SA_NUM(SA_NUM), .DIM(DIM), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .cfg_load(cfg_load), .cfg_vmode(cfg_vmode),
    .cfg_sa_num(cfg_sa_num), .cfg_base_addr(cfg_base_addr), .pool_rd_en(pool_rd_en),
    .pool_data(pool_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .fifo_full(fifo_full), .busy(busy), .err_overflow(err_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state and reference model
  int          n_checks;
  int          n_errors;
  logic [W-1:0] exp_q [SA_NUM][$];
  int          gnt_log[$];
  int          wr_cnt;
  logic        m_vmode;
  int          m_sa;
  int          m_base;
  int          n_push [SA_NUM];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Address the n-th accepted push of SA sa should land on, straight from the addressing rules.
  function automatic logic [ADDR_W-1:0] exp_addr(input int sa, input int n);
    int c, stride, b;
    if (m_vmode) begin
      c = DIM; stride = DIM; b = m_base;
    end else begin
      c = DIM * m_sa; stride = c * m_sa; b = m_base + sa * c;
    end
    return ADDR_W'(b + (n / c) * stride + (n % c));
  endfunction

  function automatic int pending();
    int t = 0;
    for (int i = 0; i < SA_NUM; i++) t += exp_q[i].size();
    return t;
  endfunction

  function automatic logic [DATA_W-1:0] make_data(input int sa, input int lane);
    logic [1:0]  s2;
    logic [1:0]  l2;
    logic [11:0] r;
    s2 = 2'(sa);
    l2 = 2'(lane);
    r  = 12'($urandom_range(0, 4095));
    return {s2, l2, r};
  endfunction

  // driver tasks: called at a negedge, return one negedge later
  task automatic do_push(input logic [SA_NUM-1:0] mask, input int lane,
                         input logic [SA_NUM-1:0] accept);
    logic [DATA_W-1:0] d;
    pool_rd_en = '0;
    pool_data  = '0;
    for (int s = 0; s < SA_NUM; s++) begin
      if (mask[s]) begin
        d = make_data(s, lane);
        pool_rd_en[s*DIM + lane] = 1'b1;
        pool_data[(s*DIM + lane)*DATA_W +: DATA_W] = d;
        if (lane < DIM - 1) begin
          pool_rd_en[s*DIM + lane + 1] = 1'b1;
          pool_data[(s*DIM + lane + 1)*DATA_W +: DATA_W] = 16'hdead;
        end
        if (accept[s]) begin
          exp_q[s].push_back({exp_addr(s, n_push[s]), d});
          n_push[s]++;
        end
      end
    end
    @(negedge clk);
    pool_rd_en = '0;
    pool_data  = '0;
  endtask

  task automatic do_cfg(input logic vm, input int sa, input int base,
                        input logic [SA_NUM-1:0] push_mask);
    m_vmode = vm;
    m_sa    = (sa > SA_NUM) ? SA_NUM : sa;
    m_base  = base;
    for (int i = 0; i < SA_NUM; i++) begin
      n_push[i] = 0;
      exp_q[i].delete();
    end
    cfg_vmode     = vm;
    cfg_sa_num    = SN_W'(sa);
    cfg_base_addr = ADDR_W'(base);
    cfg_load      = 1'b1;
    for (int s = 0; s < SA_NUM; s++) begin
      if (push_mask[s]) begin
        pool_rd_en[s*DIM] = 1'b1;
        pool_data[s*DIM*DATA_W +: DATA_W] = make_data(s, 0);
      end
    end
    @(negedge clk);
    cfg_load   = 1'b0;
    pool_rd_en = '0;
    pool_data  = '0;
  endtask

  task automatic drain(input int max_cyc);
    int c = 0;
    while ((busy || pending() != 0) && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    #3;
    check("drain_busy", 64'(busy), 64'd0);
    check("drain_pending", 64'(pending()), 64'd0);
  endtask

  // write monitor: sampled mid-cycle, the handshake completes at the next posedge
  always begin
    int s;
    logic [W-1:0] e;
    @(negedge clk);
    #2;
    if (resetn && wr_valid && wr_ready && !cfg_load) begin
      s = int'(wr_data[DATA_W-1 -: 2]);
      gnt_log.push_back(s);
      wr_cnt++;
      check("write_expected", 64'(exp_q[s].size() > 0), 64'd1);
      if (exp_q[s].size() > 0) begin
        e = exp_q[s].pop_front();
        check("write_addr", 64'(wr_addr), 64'(e[W-1:DATA_W]));
        check("write_data", 64'(wr_data), 64'(e[DATA_W-1:0]));
      end
    end
  end

  int w0;
  int g0;

  initial begin
    n_checks = 0; n_errors = 0; wr_cnt = 0;
    m_vmode = 1'b0; m_sa = 0; m_base = 0;
    for (int i = 0; i < SA_NUM; i++) n_push[i] = 0;
    resetn = 1'b0; cfg_load = 1'b0; cfg_vmode = 1'b0; cfg_sa_num = '0;
    cfg_base_addr = '0; pool_rd_en = '0; pool_data = '0; wr_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_wr_valid", 64'(wr_valid), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_fifo_full", 64'(fifo_full), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_overflow), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // reset configuration has no active SA
    do_push(4'b0001, 0, 4'b0000);
    repeat (3) @(negedge clk);
    check("unconfigured_busy", 64'(busy), 64'd0);
    check("unconfigured_writes", 64'(wr_cnt), 64'd0);

    // horizontal sweep, SA2 inactive
    wr_ready = 1'b1;
    do_cfg(1'b0, 2, 'h100, 4'b0000);
    w0 = wr_cnt;
    for (int k = 0; k < 9; k++) begin
      do_push((k < 8) ? 4'b0111 : 4'b0001, $urandom_range(0, DIM - 1),
              (k < 8) ? 4'b0011 : 4'b0001);
      repeat (5) @(negedge clk);
    end
    drain(200);
    check("hsweep_writes", 64'(wr_cnt - w0), 64'd17);
    check("hsweep_err", 64'(err_overflow), 64'd0);

    // vertical mode, only SA2 active
    do_cfg(1'b1, 3, 'h40, 4'b0000);
    w0 = wr_cnt;
    for (int k = 0; k < 9; k++) begin
      do_push(4'b1111, $urandom_range(0, DIM - 1), 4'b0100);
      repeat (2) @(negedge clk);
    end
    drain(200);
    check("vmode_writes", 64'(wr_cnt - w0), 64'd9);

    // backpressure: one entry latched in the output stage, then 5 pushes into SA0
    wr_ready = 1'b0;
    do_cfg(1'b0, 1, 'h200, 4'b0000);
    w0 = wr_cnt;
    do_push(4'b0001, 0, 4'b0001);
    repeat (2) @(negedge clk);
    check("bp_stage_valid", 64'(wr_valid), 64'd1);
    check("bp_no_err_yet", 64'(err_overflow), 64'd0);
    for (int k = 0; k < 5; k++) do_push(4'b0001, $urandom_range(0, DIM - 1), (k < 4) ? 4'b0001 : 4'b0000);
    check("bp_fifo_full", 64'(fifo_full), 64'b0001);
    check("bp_err", 64'(err_overflow), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(wr_valid), 64'd1);
      check("bp_hold_word", 64'({wr_addr, wr_data}), 64'(exp_q[0][0]));
    end
    wr_ready = 1'b1;
    drain(200);
    check("bp_writes", 64'(wr_cnt - w0), 64'd5);
    w0 = wr_cnt;
    do_push(4'b0001, 1, 4'b0001);
    drain(50);
    check("bp_after_drop_writes", 64'(wr_cnt - w0), 64'd1);

    // cfg_load flushes pending work and ignores a same-cycle push
    wr_ready = 1'b0;
    do_cfg(1'b0, 2, 'h300, 4'b0000);
    do_push(4'b0011, 0, 4'b0011);
    do_push(4'b0011, 2, 4'b0011);
    @(negedge clk);
    check("flush_busy_before", 64'(busy), 64'd1);
    w0 = wr_cnt;
    do_cfg(1'b0, 2, 'h380, 4'b0001);
    check("flush_wr_valid", 64'(wr_valid), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_fifo_full", 64'(fifo_full), 64'd0);
    wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("flush_no_write", 64'(wr_cnt - w0), 64'd0);
    do_push(4'b0001, 0, 4'b0001);
    drain(50);
    check("flush_restart_writes", 64'(wr_cnt - w0), 64'd1);

    // async reset while a write is pending
    wr_ready = 1'b0;
    do_cfg(1'b0, 1, 'h20, 4'b0000);
    do_push(4'b0001, 0, 4'b0001);
    @(negedge clk);
    check("arst_pre_valid", 64'(wr_valid), 64'd1);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_wr_valid", 64'(wr_valid), 64'd0);
    check("arst_wr_addr", 64'(wr_addr), 64'd0);
    check("arst_wr_data", 64'(wr_data), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_fifo_full", 64'(fifo_full), 64'd0);
    m_vmode = 1'b0; m_sa = 0; m_base = 0;
    for (int i = 0; i < SA_NUM; i++) begin
      n_push[i] = 0;
      exp_q[i].delete();
    end
    @(negedge clk);
    resetn = 1'b1;
    wr_ready = 1'b1;
    w0 = wr_cnt;
    do_push(4'b0001, 0, 4'b0000);
    repeat (4) @(negedge clk);
    check("arst_push_ignored_busy", 64'(busy), 64'd0);
    check("arst_push_ignored_writes", 64'(wr_cnt - w0), 64'd0);

    // round-robin from a fresh pointer with all four FIFOs loaded
    wr_ready = 1'b0;
    do_cfg(1'b0, 4, 'h000, 4'b0000);
    for (int k = 0; k < 3; k++) do_push(4'b1111, $urandom_range(0, DIM - 1), 4'b1111);
    g0 = gnt_log.size();
    w0 = wr_cnt;
    wr_ready = 1'b1;
    drain(200);
    check("rr_writes", 64'(wr_cnt - w0), 64'd12);
    for (int k = 0; k < 12; k++) begin
      if (g0 + k < gnt_log.size()) check("rr_grant", 64'(gnt_log[g0 + k]), 64'(k % SA_NUM));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
